// File: rtl/noc_vc_output_arbiter.sv
// Wormhole output-port scheduler: round-robin packet arbitration over NUM_IN
// FWFT input FIFOs, grant held until tail, credit-gated registered link output.
module noc_vc_output_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_IN-1:0]              fifo_empty,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   fifo_dout,
    output logic [NUM_IN-1:0]              fifo_rd_en,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_IN)-1:0]      out_src,
    input  logic                           credit_return,
    output logic [$clog2(CREDITS+1)-1:0]   credit_count,
    output logic                           locked,
    output logic                           credit_err,
    output logic                           proto_err
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int CNT_W = $clog2(CREDITS+1);

    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        credit_q, credit_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]        out_src_q, out_src_d;
    logic                    credit_err_q, credit_err_d;
    logic                    proto_err_q, proto_err_d;

    logic [NUM_IN-1:0]       starts_pkt;
    logic [NUM_IN-1:0]       eligible;
    logic [NUM_IN-1:0]       bad_head;
    logic                    can_send;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        cand_idx;
    int                      cand;
    logic                    pop_en;
    logic [IDX_W-1:0]        pop_idx;
    logic [DATA_WIDTH-1:0]   pop_flit;
    logic [1:0]              pop_type;
    logic [NUM_IN-1:0]       rd_en;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_IN-1) return '0;
        return idx + 1'b1;
    endfunction

    // Head and single both have the low type bit set; body and tail do not.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        assign starts_pkt[g] = fifo_dout[g*DATA_WIDTH + DATA_WIDTH-2];
        assign eligible[g]   = !fifo_empty[g] &&  starts_pkt[g];
        assign bad_head[g]   = !fifo_empty[g] && !starts_pkt[g];
    end

    assign can_send = (credit_q != '0);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_IN) cand = cand - NUM_IN;
            cand_idx = IDX_W'(cand);
            if (!win_found && eligible[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        if (state_q == IDLE) begin
            pop_en  = can_send && win_found;
            pop_idx = win_idx;
        end else begin
            pop_en  = can_send && !fifo_empty[owner_q];
            pop_idx = owner_q;
        end
        pop_flit = fifo_dout[int'(pop_idx)*DATA_WIDTH +: DATA_WIDTH];
        pop_type = pop_flit[DATA_WIDTH-1 -: 2];
        rd_en    = '0;
        if (pop_en && rst_n) rd_en[pop_idx] = 1'b1;
    end

    assign fifo_rd_en = rd_en;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        proto_err_d  = proto_err_q;
        out_valid_d  = pop_en;
        out_data_d   = pop_en ? pop_flit : out_data_q;
        out_src_d    = pop_en ? pop_idx  : out_src_q;

        case (state_q)
            IDLE: begin
                if (|bad_head) proto_err_d = 1'b1;
                if (pop_en) begin
                    if (pop_type == FT_SINGLE) begin
                        rr_ptr_d = idx_inc(win_idx);
                    end else begin
                        state_d = LOCKED;
                        owner_d = win_idx;
                    end
                end
            end
            LOCKED: begin
                if (pop_en) begin
                    if (pop_type == FT_TAIL) begin
                        state_d  = IDLE;
                        rr_ptr_d = idx_inc(owner_q);
                    end else if (pop_type == FT_HEAD || pop_type == FT_SINGLE) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop and a return in the same cycle cancel out.
        case ({pop_en, credit_return})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CNT_W'(CREDITS)) credit_err_d = 1'b1;
                else                             credit_d     = credit_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            credit_q     <= CNT_W'(CREDITS);
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            credit_err_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_q     <= credit_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            credit_err_q <= credit_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_src      = out_src_q;
    assign credit_count = credit_q;
    assign locked       = (state_q == LOCKED);
    assign credit_err   = credit_err_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_noc_vc_output_arbiter.sv
// Directed bench for noc_vc_output_arbiter: queue-based FWFT FIFO models on
// the inputs and a scoreboard of expected link flits.
module tb_noc_vc_output_arbiter;

    localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, SNGL = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   fifo_empty;
    logic [255:0] fifo_dout;
    logic [3:0]   fifo_rd_en;
    logic         out_valid;
    logic [63:0]  out_data;
    logic [1:0]   out_src;
    logic         credit_return;
    logic [2:0]   credit_count;
    logic         locked;
    logic         credit_err;
    logic         proto_err;

    typedef struct {
        logic [1:0]  src;
        logic [63:0] data;
    } exp_t;

    logic [63:0] fq [4][$];
    exp_t        sb [$];
    logic [3:0]  rd_lat;
    int          vectors     = 0;
    int          miscompares = 0;
    int          pl          = 1;

    noc_vc_output_arbiter #(.NUM_IN(4), .DATA_WIDTH(64), .CREDITS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_src       (out_src),
        .credit_return (credit_return),
        .credit_count  (credit_count),
        .locked        (locked),
        .credit_err    (credit_err),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i] = (fq[i].size() == 0);
            fifo_dout[i*64 +: 64] = (fq[i].size() == 0) ? 64'd0 : fq[i][0];
        end
    endtask

    task automatic load(input int i, input logic [1:0] t, input bit expect_out);
        logic [63:0] f;
        f = {t, 62'(pl)};
        pl++;
        fq[i].push_back(f);
        if (expect_out) sb.push_back('{src: 2'(i), data: f});
        refresh();
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) fq[i].delete();
        refresh();
    endtask

    // One clock: monitor the link at the falling edge, latch the pop request,
    // then retire popped flits from the FIFO models just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_flit", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("out_src", {62'd0, out_src}, {62'd0, e.src});
                check("out_data", out_data, e.data);
            end
        end
        rd_lat = fifo_rd_en;
        check("rd_onehot0", {63'd0, $onehot0(rd_lat)}, 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (rd_lat[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        refresh();
    endtask

    task automatic step(input string tag, input logic [3:0] rd_exp);
        tick();
        check(tag, {60'd0, rd_lat}, {60'd0, rd_exp});
    endtask

    task automatic give_credits(input int n);
        credit_return = 1'b1;
        repeat (n) tick();
        credit_return = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        credit_return = 1'b0;
        rd_lat = '0;
        refresh();
        repeat (2) @(posedge clk);
        #1;

        // Reset held with every FIFO offering a single flit.
        for (int i = 0; i < 4; i++) load(i, SNGL, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step("rst_rd_en", 4'b0000);
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_credit", {61'd0, credit_count}, 64'd4);
            check("rst_locked", {63'd0, locked}, 64'd0);
        end
        check("rst_credit_err", {63'd0, credit_err}, 64'd0);
        check("rst_proto_err", {63'd0, proto_err}, 64'd0);
        rst_n = 1'b1;

        // Round-robin over four singles, then credit exhaustion.
        step("rr_pop0", 4'b0001);
        step("rr_pop1", 4'b0010);
        step("rr_pop2", 4'b0100);
        step("rr_pop3", 4'b1000);
        check("rr_credit0", {61'd0, credit_count}, 64'd0);
        load(0, SNGL, 1'b1);
        step("nocredit_a", 4'b0000);
        step("nocredit_b", 4'b0000);
        credit_return = 1'b1;
        step("ret_same_cycle", 4'b0000);
        credit_return = 1'b0;
        check("ret_credit1", {61'd0, credit_count}, 64'd1);
        step("after_ret_pop0", 4'b0001);
        check("after_ret_credit0", {61'd0, credit_count}, 64'd0);
        give_credits(4);
        check("refill_credit4", {61'd0, credit_count}, 64'd4);

        // Wormhole lock: input 1 packet holds off input 2's single.
        load(1, HEAD, 1'b1);
        load(1, BODY, 1'b1);
        load(1, TAIL, 1'b1);
        load(2, SNGL, 1'b1);
        step("wh_head", 4'b0010);
        check("wh_locked_h", {63'd0, locked}, 64'd1);
        step("wh_body", 4'b0010);
        check("wh_locked_b", {63'd0, locked}, 64'd1);
        step("wh_tail", 4'b0010);
        check("wh_unlocked", {63'd0, locked}, 64'd0);
        step("wh_next", 4'b0100);
        give_credits(4);
        check("wh_sb_drained", 64'(sb.size()), 64'd0);

        // Credit stall in the middle of a 6-flit packet on input 3.
        load(3, HEAD, 1'b1);
        for (int b = 0; b < 4; b++) load(3, BODY, 1'b1);
        load(3, TAIL, 1'b1);
        for (int f = 0; f < 4; f++) step("st_burst", 4'b1000);
        check("st_credit0", {61'd0, credit_count}, 64'd0);
        step("st_stall_a", 4'b0000);
        step("st_stall_b", 4'b0000);
        check("st_locked", {63'd0, locked}, 64'd1);
        credit_return = 1'b1;
        step("st_ret_only", 4'b0000);
        check("st_credit1", {61'd0, credit_count}, 64'd1);
        step("st_flit5", 4'b1000);
        check("st_pop_ret_same", {61'd0, credit_count}, 64'd1);
        credit_return = 1'b0;
        step("st_flit6", 4'b1000);
        check("st_credit_end", {61'd0, credit_count}, 64'd0);
        check("st_unlocked", {63'd0, locked}, 64'd0);
        give_credits(4);
        check("st_sb_drained", 64'(sb.size()), 64'd0);

        // Credit return while already full.
        check("ovf_err_before", {63'd0, credit_err}, 64'd0);
        give_credits(1);
        check("ovf_credit", {61'd0, credit_count}, 64'd4);
        check("ovf_err", {63'd0, credit_err}, 64'd1);
        repeat (3) tick();
        check("ovf_err_sticky", {63'd0, credit_err}, 64'd1);

        // Body flit at a FIFO head while idle.
        check("pe_before", {63'd0, proto_err}, 64'd0);
        load(3, BODY, 1'b0);
        step("pe_no_pop_a", 4'b0000);
        check("pe_set", {63'd0, proto_err}, 64'd1);
        step("pe_no_pop_b", 4'b0000);
        fq[3].delete();
        refresh();

        // Reset after head plus one body flit.
        load(0, SNGL, 1'b1);
        step("mr_single0", 4'b0001);
        load(2, HEAD, 1'b1);
        load(2, BODY, 1'b1);
        load(2, BODY, 1'b0);
        load(2, TAIL, 1'b0);
        step("mr_head", 4'b0100);
        check("mr_locked", {63'd0, locked}, 64'd1);
        step("mr_body", 4'b0100);
        rst_n = 1'b0;
        step("mr_rst_gate", 4'b0000);
        check("mr_unlocked", {63'd0, locked}, 64'd0);
        check("mr_credit", {61'd0, credit_count}, 64'd4);
        check("mr_out_valid", {63'd0, out_valid}, 64'd0);
        check("mr_credit_err", {63'd0, credit_err}, 64'd0);
        check("mr_proto_err", {63'd0, proto_err}, 64'd0);
        flush();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) load(i, SNGL, 1'b1);
        step("mr_rr0", 4'b0001);
        step("mr_rr1", 4'b0010);
        step("mr_rr2", 4'b0100);
        step("mr_rr3", 4'b1000);
        repeat (2) tick();
        check("final_sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/noc_vc_output_arbiter.md
# noc_vc_output_arbiter

Wormhole output-port scheduler sitting between `NUM_IN` per-input flit FIFOs (first-word-fall-through, combinational `dout`/`empty`) and one router output link. It picks packets round-robin among non-empty inputs and holds the grant until the packet's tail flit has passed. It pops the winning FIFO and registers the flit onto the link. Flits are sent only when the downstream buffer has credit, so the downstream FIFO can never overflow.

## Interface
Parameters:
- `NUM_IN`, 4, number of input FIFOs (≥2).
- `DATA_WIDTH`, 64, flit width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the flit type: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).
- `CREDITS`, 4, downstream buffer depth, which is also the initial credit count.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `fifo_empty`  in  NUM_IN  per-input FIFO empty.
- `fifo_dout`  in  NUM_IN*DATA_WIDTH  per-input FIFO head flit. Input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `fifo_rd_en`  out  NUM_IN  per-input pop, combinational, one-hot or zero.
- `out_valid`  out  1  registered flit valid on the link.
- `out_data`  out  DATA_WIDTH  registered flit.
- `out_src`  out  $clog2(NUM_IN)  input index the flit came from.
- `credit_return`  in  1  downstream freed one slot (one-cycle pulse, one credit).
- `credit_count`  out  $clog2(CREDITS+1)  current credits.
- `locked`  out  1  high while in LOCKED.
- `credit_err`  out  1  sticky; set when a credit is returned while already at CREDITS.
- `proto_err`  out  1  sticky; set on an illegal flit type (see Operation).

## Operation
- The FSM has two states, IDLE and LOCKED.
- Internal registers: `owner` (input index) and `rr_ptr` (index of the highest-priority input).
- `can_send` = `credit_count != 0`. It uses the registered count only; a same-cycle `credit_return` does not enable a send.

IDLE:
- An input is eligible when its FIFO is non-empty and its head flit type is head or single.
- If `can_send` and any input is eligible, the winner is the first eligible index at or after `rr_ptr`, wrapping modulo NUM_IN. `fifo_rd_en[winner]` is asserted that cycle.
- Winner flit of type single: stay in IDLE; `rr_ptr` <= winner+1 (mod NUM_IN).
- Winner flit of type head: go to LOCKED; `owner` <= winner.
- A non-empty input whose head flit is body or tail is never eligible, and sets `proto_err`.

LOCKED:
- Only `owner` may pop. `fifo_rd_en[owner]` is asserted when `!fifo_empty[owner] && can_send`. All other inputs wait.
- A popped tail flit returns the FSM to IDLE with `rr_ptr` <= owner+1 (mod NUM_IN).
- A popped head or single flit sets `proto_err`, is still forwarded, and the FSM stays LOCKED.
- An empty owner FIFO stalls the FSM in LOCKED indefinitely; there is no timeout.

Credits:
- Decrement on any pop. Increment on `credit_return`. Both in the same cycle leaves the count unchanged.
- `credit_return` alone at CREDITS: the count stays at CREDITS and `credit_err` is set.
- The count never underflows, because pops require `can_send`.

General:
- At most one pop per cycle.
- `fifo_rd_en` is forced to 0 while `rst_n` is low.

## Timing
- Reset values: state IDLE; `owner` 0; `rr_ptr` 0; `out_valid` 0; `out_data` 0; `out_src` 0; `credit_count` CREDITS; `locked` 0; `credit_err` 0; `proto_err` 0.
- Latency: pop in cycle N gives `out_valid`/`out_data`/`out_src` in cycle N+1. `out_valid` lasts exactly one cycle per flit.
- The link has no backpressure other than credits.
- Throughput is one flit per cycle:
  - back-to-back single-flit packets from different inputs;
  - head followed immediately by body flits;
  - a tail followed the next cycle by a new head from another input.
- `credit_count` and `locked` are registered; their new values appear the cycle after the pop or return.
- Reset asserted mid-packet aborts the packet: the FSM returns to IDLE and credits return to CREDITS on the next edge. Upstream and downstream are reset together.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with all FIFOs non-empty holding single flits. Require `fifo_rd_en`=0, `out_valid`=0 and `credit_count`=4 throughout. In the first cycle after release, input 0 is popped.
- **Round-robin.** Inputs 0–3 each hold one single flit, CREDITS=4. Require pops on 4 consecutive cycles, `out_src` sequence 0,1,2,3, then `credit_count`=0. No further pop until `credit_return` is pulsed.
- **Wormhole lock.** Input 1 holds head/body/tail; input 2 holds a single; `rr_ptr`=1. Require `out_src` sequence 1,1,1,2 on consecutive cycles, with `locked`=1 across the packet. Input 2 is not popped before input 1's tail.
- **Credit stall mid-packet.** A 6-flit packet with CREDITS=4. Require 4 flits sent, then a stall with `locked`=1. Two `credit_return` pulses release flits 5 and 6. A `credit_return` coincident with a pop leaves `credit_count` unchanged.
- **Credit overflow.** Pulse `credit_return` with `credit_count`=4. Require the count stays 4 and `credit_err`=1, remaining high until reset.
- **Protocol / mid-packet reset.** A body flit at the head of input 3 while in IDLE: require no pop of input 3 and `proto_err`=1. Separately, assert reset after the head plus 1 body flit: require IDLE, `locked`=0, `credit_count`=4 and `rr_ptr`=0.
